// File: rtl/maze_game_ctrl.sv
// Play-state sequencer for the VGA maze: debounces the buttons, issues at most one
// move per frame, judges wall/goal hits reported by the renderer and tracks lives.
module maze_game_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LIVES           = 3,
  parameter int HIT_FRAMES      = 60,
  parameter int END_FRAMES      = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_right_n,
  input  logic       btn_start_n,
  input  logic       wall_hit,
  input  logic       goal_hit,
  output logic       move_up,
  output logic       move_down,
  output logic       move_right,
  output logic       square_reset,
  output logic [2:0] state,
  output logic [2:0] lives
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int FMAX = (HIT_FRAMES > END_FRAMES) ? HIT_FRAMES : END_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] HIT_LAST = FW'(HIT_FRAMES - 1);
  localparam logic [FW-1:0] END_CNT  = FW'(END_FRAMES);
  localparam logic [2:0]    LIVES_I  = 3'(LIVES);

  // Button vector order: [0] up, [1] down, [2] right, [3] start (all active-low).
  logic [3:0]    btn_raw;
  logic [3:0]    sync1, sync2, btn_acc;
  logic [DW-1:0] db_cnt [4];
  logic          start_q;
  logic          start_evt;

  assign btn_raw = {btn_start_n, btn_right_n, btn_down_n, btn_up_n};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 4'hF;
      sync2   <= 4'hF;
      btn_acc <= 4'hF;
      start_q <= 1'b1;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      start_q <= btn_acc[3];
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != btn_acc[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            btn_acc[i] <= sync2[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign start_evt = start_q & ~btn_acc[3];

  // Renderer flags raised on the tick itself belong to the following frame.
  logic hit_flag, goal_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_flag  <= 1'b0;
      goal_flag <= 1'b0;
    end else if (frame_tick) begin
      hit_flag  <= wall_hit;
      goal_flag <= goal_hit;
    end else begin
      hit_flag  <= hit_flag | wall_hit;
      goal_flag <= goal_flag | goal_hit;
    end
  end

  state_t        state_q, state_n;
  logic [2:0]    lives_q, lives_n;
  logic [FW-1:0] fcnt_q, fcnt_n;
  logic          mu_n, md_n, mr_n, sr_n;
  logic          mu_q, md_q, mr_q, sr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lives_q <= LIVES_I;
      fcnt_q  <= '0;
      mu_q    <= 1'b0;
      md_q    <= 1'b0;
      mr_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      fcnt_q  <= fcnt_n;
      mu_q    <= mu_n;
      md_q    <= md_n;
      mr_q    <= mr_n;
      sr_q    <= sr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    lives_n = lives_q;
    fcnt_n  = fcnt_q;
    mu_n    = 1'b0;
    md_n    = 1'b0;
    mr_n    = 1'b0;
    sr_n    = 1'b0;
    case (state_q)
      S_IDLE: begin
        lives_n = LIVES_I;
        if (start_evt) begin
          state_n = S_PLAY;
          sr_n    = 1'b1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (hit_flag) begin
            lives_n = lives_q - 3'd1;
            sr_n    = 1'b1;
            fcnt_n  = '0;
            state_n = (lives_q == 3'd1) ? S_LOSE : S_HIT;
          end else if (goal_flag) begin
            fcnt_n  = '0;
            state_n = S_WIN;
          end else if (!btn_acc[0]) begin
            mu_n = 1'b1;
          end else if (!btn_acc[1]) begin
            md_n = 1'b1;
          end else if (!btn_acc[2]) begin
            mr_n = 1'b1;
          end
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          if (fcnt_q == HIT_LAST) begin
            fcnt_n  = '0;
            state_n = S_PLAY;
          end else begin
            fcnt_n = fcnt_q + 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        // The frame count saturates at END_FRAMES; only then is start honoured.
        if (start_evt && fcnt_q >= END_CNT) begin
          fcnt_n  = '0;
          lives_n = LIVES_I;
          state_n = S_IDLE;
        end else if (frame_tick && fcnt_q < END_CNT) begin
          fcnt_n = fcnt_q + 1'b1;
        end
      end
      default: begin
        fcnt_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign move_up      = mu_q;
  assign move_down    = md_q;
  assign move_right   = mr_q;
  assign square_reset = sr_q;
  assign state        = state_q;
  assign lives        = lives_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl with short debounce and frame parameters.
module tb_maze_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_up_n, btn_down_n, btn_right_n, btn_start_n;
  logic       wall_hit, goal_hit;
  logic       move_up, move_down, move_right, square_reset;
  logic [2:0] state, lives;

  int n_checks = 0;
  int n_errors = 0;

  maze_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LIVES(2),
    .HIT_FRAMES(2),
    .END_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n),
    .btn_right_n(btn_right_n),
    .btn_start_n(btn_start_n),
    .wall_hit(wall_hit),
    .goal_hit(goal_hit),
    .move_up(move_up),
    .move_down(move_down),
    .move_right(move_right),
    .square_reset(square_reset),
    .state(state),
    .lives(lives)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic hold_start(input int n, output int pulses);
    pulses = 0;
    btn_start_n = 1'b0;
    repeat (n) begin
      step();
      if (square_reset) pulses++;
    end
    btn_start_n = 1'b1;
  endtask

  task automatic pulse_flags(input logic w, input logic g);
    wall_hit = w;
    goal_hit = g;
    step();
    wall_hit = 1'b0;
    goal_hit = 1'b0;
    wait_n(3);
  endtask

  int p;
  int first_sr;

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    btn_up_n = 1'b1; btn_down_n = 1'b1; btn_right_n = 1'b1; btn_start_n = 1'b1;
    wall_hit = 1'b0; goal_hit = 1'b0;
    wait_n(2);
    check("rst_state", state, 0);
    check("rst_lives", lives, 2);
    check("rst_moves", {move_up, move_down, move_right}, 0);
    check("rst_sr", square_reset, 0);
    rst_n = 1'b1;
    wait_n(2);

    // Short press never satisfies debounce
    hold_start(3, p);
    check("short_sr", p, 0);
    wait_n(8);
    check("short_state", state, 0);

    hold_start(10, p);
    check("start_sr_count", p, 1);
    check("start_state", state, 1);
    check("start_lives", lives, 2);
    wait_n(8);

    // up + right held: up wins, one pulse per tick
    btn_up_n = 1'b0; btn_right_n = 1'b0;
    wait_n(8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("up_pulse", {move_up, move_down, move_right, square_reset}, 4'b1000);
      step();
      check("up_one_cycle", {move_up, move_down, move_right}, 0);
    end
    btn_up_n = 1'b1; btn_down_n = 1'b0;
    wait_n(8);
    tick();
    check("down_over_right", {move_up, move_down, move_right}, 3'b010);
    btn_down_n = 1'b1;
    wait_n(8);
    tick();
    check("right_alone", {move_up, move_down, move_right}, 3'b001);
    btn_right_n = 1'b1;
    wait_n(8);
    tick();
    check("no_btn", {move_up, move_down, move_right}, 0);

    // Wall mid-frame
    pulse_flags(1'b1, 1'b0);
    tick();
    check("hit1_sr", square_reset, 1);
    check("hit1_lives", lives, 1);
    check("hit1_state", state, 2);
    check("hit1_moves", {move_up, move_down, move_right}, 0);
    btn_up_n = 1'b0;
    wait_n(8);
    tick();
    check("hit_frame1_moves", {move_up, move_down, move_right}, 0);
    check("hit_frame1_state", state, 2);
    tick();
    check("hit_frame2_moves", {move_up, move_down, move_right}, 0);
    check("hit_frame2_state", state, 1);
    tick();
    check("resume_move", {move_up, move_down, move_right}, 3'b100);

    // Wall coinciding with tick is judged on the next tick
    wall_hit = 1'b1;
    tick();
    wall_hit = 1'b0;
    check("defer_state", state, 1);
    check("defer_move", {move_up, square_reset}, 2'b10);
    tick();
    check("lose_state", state, 4);
    check("lose_lives", lives, 0);
    check("lose_sr", {move_up, square_reset}, 2'b01);
    btn_up_n = 1'b1;
    wait_n(8);

    hold_start(8, p);
    check("early_start_ignored", state, 4);
    wait_n(8);
    tick();
    tick();
    check("lose_wait_state", state, 4);
    hold_start(8, p);
    check("late_start_state", state, 0);
    check("late_start_lives", lives, 2);
    wait_n(8);

    // Wall and goal together: wall wins
    hold_start(8, p);
    check("replay_state", state, 1);
    wait_n(8);
    pulse_flags(1'b1, 1'b1);
    tick();
    check("both_state", state, 2);
    check("both_lives", lives, 1);
    tick();
    tick();
    check("both_back_play", state, 1);
    btn_up_n = 1'b0;
    wait_n(8);
    pulse_flags(1'b0, 1'b1);
    tick();
    check("goal_state", state, 3);
    check("goal_no_move", {move_up, move_down, move_right, square_reset}, 0);
    check("goal_lives", lives, 1);
    btn_up_n = 1'b1;
    wait_n(8);

    tick();
    tick();
    hold_start(8, p);
    check("win_to_idle", state, 0);
    wait_n(8);
    hold_start(8, p);
    wait_n(8);
    pulse_flags(1'b1, 1'b0);
    tick();
    check("pre_rst_state", state, 2);

    // Reset in HIT with start mid-debounce; debounce must restart from scratch
    btn_start_n = 1'b0;
    wait_n(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_state", state, 0);
    check("mid_rst_lives", lives, 2);
    check("mid_rst_pulses", {move_up, move_down, move_right, square_reset}, 0);
    first_sr = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (square_reset && first_sr == 0) first_sr = i;
    end
    check("rst_redebounce_cycle", first_sr, 7);
    btn_start_n = 1'b1;
    wait_n(8);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
